// File: rtl/issue_arbiter_pkg.sv
// Shared issue-path types: stage record and default tag widths used by the RS,
// ROB and issue arbiter.
package issue_arbiter_pkg;

  localparam int DEF_PR_BITS  = 6;
  localparam int DEF_ROB_BITS = 4;

  typedef struct packed {
    logic                    valid;
    logic [DEF_PR_BITS-1:0]  dst;
    logic [DEF_ROB_BITS-1:0] rob_idx;
  } stage_t;

  // Index width that stays legal for a single-requester configuration.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/issue_arbiter_rr_picker.sv
// Round-robin picker: first set request at or after ptr, wrapping modulo N.
// Purely combinational; one-hot grant plus binary index.
module rr_picker #(
  parameter int N     = 4,
  parameter int SEL_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [SEL_W-1:0] idx,
  output logic             any
);

  always_comb begin
    int t;
    logic [SEL_W-1:0] j;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    t   = 0;
    j   = '0;
    for (int i = 0; i < N; i++) begin
      t = int'(ptr) + i;
      if (t >= N) t = t - N;
      j = SEL_W'(t);
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = j;
      end
    end
  end

endmodule

// File: rtl/issue_arbiter.sv
// Issue arbiter: round-robin select among ready RSs, same-cycle grant to a
// fixed-latency FU, and CDB writeback after FU_LAT unstalled cycles.
module issue_arbiter
  import issue_arbiter_pkg::*;
#(
  parameter int NUM_RS   = 4,
  parameter int PR_BITS  = DEF_PR_BITS,
  parameter int ROB_BITS = DEF_ROB_BITS,
  parameter int FU_LAT   = 3,
  localparam int SEL_W   = sel_width(NUM_RS),
  localparam int CNT_W   = $clog2(FU_LAT + 1)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_RS-1:0]                req_valid,
  input  logic [NUM_RS-1:0][PR_BITS-1:0]   req_dst,
  input  logic [NUM_RS-1:0][ROB_BITS-1:0]  req_rob_idx,
  input  logic                             fu_stall,
  input  logic                             flush,
  output logic [NUM_RS-1:0]                grant,
  output logic                             fu_issue_valid,
  output logic [SEL_W-1:0]                 fu_issue_sel,
  output logic [PR_BITS-1:0]               fu_issue_dst,
  output logic [ROB_BITS-1:0]              fu_issue_rob_idx,
  output logic                             wb_valid,
  output logic [PR_BITS-1:0]               wb_phys,
  output logic [ROB_BITS-1:0]              wb_rob_idx,
  output logic [CNT_W-1:0]                 inflight_cnt,
  output logic                             busy
);

  logic [NUM_RS-1:0] req_elig;
  logic [NUM_RS-1:0] pick_gnt;
  logic [SEL_W-1:0]  pick_idx;
  logic              pick_any;
  logic [SEL_W-1:0]  rr_ptr;

  stage_t [FU_LAT-1:0] pipe_q;
  stage_t [FU_LAT-1:0] pipe_d;
  stage_t              last;

  function automatic logic [CNT_W-1:0] count_valid(input stage_t [FU_LAT-1:0] p);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int k = 0; k < FU_LAT; k++) c = c + CNT_W'(p[k].valid);
    return c;
  endfunction

  // Stall and flush both suppress issue, so the picker never sees requests then.
  assign req_elig = (fu_stall || flush) ? '0 : req_valid;

  rr_picker #(
    .N     (NUM_RS),
    .SEL_W (SEL_W)
  ) u_picker (
    .req (req_elig),
    .ptr (rr_ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign grant            = pick_gnt;
  assign fu_issue_valid   = pick_any;
  assign fu_issue_sel     = pick_any ? pick_idx : '0;
  assign fu_issue_dst     = pick_any ? req_dst[pick_idx] : '0;
  assign fu_issue_rob_idx = pick_any ? req_rob_idx[pick_idx] : '0;

  // Flush wins over stall; a stalled pipe holds every stage in place.
  always_comb begin
    pipe_d = pipe_q;
    if (flush) begin
      pipe_d = '0;
    end else if (!fu_stall) begin
      pipe_d[0].valid   = pick_any;
      pipe_d[0].dst     = fu_issue_dst;
      pipe_d[0].rob_idx = fu_issue_rob_idx;
      for (int k = 1; k < FU_LAT; k++) pipe_d[k] = pipe_q[k-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_q       <= '0;
      inflight_cnt <= '0;
      rr_ptr       <= '0;
    end else begin
      pipe_q       <= pipe_d;
      inflight_cnt <= count_valid(pipe_d);
      if (pick_any)
        rr_ptr <= (pick_idx == SEL_W'(NUM_RS - 1)) ? '0 : pick_idx + SEL_W'(1);
    end
  end

  assign last       = pipe_q[FU_LAT-1];
  assign wb_valid   = last.valid && !fu_stall && !flush;
  assign wb_phys    = wb_valid ? last.dst : '0;
  assign wb_rob_idx = wb_valid ? last.rob_idx : '0;
  assign busy       = (inflight_cnt != '0);

endmodule

// File: tb/tb_issue_arbiter.sv
// Self-checking bench for issue_arbiter: grant table, directed stall/flush/reset
// sequences, and randomized traffic against an op-age queue model.
module tb_issue_arbiter;

  localparam int NUM_RS   = 4;
  localparam int PR_BITS  = 6;
  localparam int ROB_BITS = 4;
  localparam int FU_LAT   = 3;

  logic                            clk = 1'b0;
  logic                            rst_n;
  logic [NUM_RS-1:0]               req_valid;
  logic [NUM_RS-1:0][PR_BITS-1:0]  req_dst;
  logic [NUM_RS-1:0][ROB_BITS-1:0] req_rob_idx;
  logic                            fu_stall, flush;
  logic [NUM_RS-1:0]               grant;
  logic                            fu_issue_valid;
  logic [1:0]                      fu_issue_sel;
  logic [PR_BITS-1:0]              fu_issue_dst;
  logic [ROB_BITS-1:0]             fu_issue_rob_idx;
  logic                            wb_valid;
  logic [PR_BITS-1:0]              wb_phys;
  logic [ROB_BITS-1:0]             wb_rob_idx;
  logic [1:0]                      inflight_cnt;
  logic                            busy;

  always #5 clk = ~clk;

  issue_arbiter #(
    .NUM_RS(NUM_RS), .PR_BITS(PR_BITS), .ROB_BITS(ROB_BITS), .FU_LAT(FU_LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_dst(req_dst),
    .req_rob_idx(req_rob_idx), .fu_stall(fu_stall), .flush(flush), .grant(grant),
    .fu_issue_valid(fu_issue_valid), .fu_issue_sel(fu_issue_sel),
    .fu_issue_dst(fu_issue_dst), .fu_issue_rob_idx(fu_issue_rob_idx),
    .wb_valid(wb_valid), .wb_phys(wb_phys), .wb_rob_idx(wb_rob_idx),
    .inflight_cnt(inflight_cnt), .busy(busy)
  );

  int checks = 0;
  int errors = 0;

  // Model: each in-flight op carries its age in unstalled edges since grant.
  typedef struct {
    int dst;
    int rob;
    int age;
  } op_t;

  op_t q[$];
  int  m_ptr  = 0;
  int  cur_idx = -1;

  typedef struct {
    logic [3:0] rv;
    logic       st;
    logic       fl;
    logic [3:0] g;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", name, got, exp);
    end
  endtask

  task automatic set_fields;
    for (int i = 0; i < NUM_RS; i++) begin
      req_dst[i]     = PR_BITS'(10 + i);
      req_rob_idx[i] = ROB_BITS'(i + 1);
    end
  endtask

  // Apply inputs for this cycle, then compare every output to the model.
  task automatic drive(input logic [3:0] rv, input logic st, input logic fl);
    int e_idx, j, wd, wr;
    logic ew;
    logic [1:0] ei;
    req_valid = rv;
    fu_stall  = st;
    flush     = fl;
    #2;
    e_idx = -1;
    if (!st && !fl) begin
      for (int i = 0; i < NUM_RS; i++) begin
        j = (m_ptr + i) % NUM_RS;
        if (rv[j] && e_idx < 0) e_idx = j;
      end
    end
    ei = 2'(e_idx);
    chk("grant", 32'(grant), (e_idx >= 0) ? (32'd1 << e_idx) : 32'd0);
    chk("issue_valid", 32'(fu_issue_valid), (e_idx >= 0) ? 32'd1 : 32'd0);
    chk("issue_sel", 32'(fu_issue_sel), (e_idx >= 0) ? 32'(e_idx) : 32'd0);
    chk("issue_dst", 32'(fu_issue_dst), (e_idx >= 0) ? 32'(req_dst[ei]) : 32'd0);
    chk("issue_rob", 32'(fu_issue_rob_idx), (e_idx >= 0) ? 32'(req_rob_idx[ei]) : 32'd0);
    ew = 1'b0; wd = 0; wr = 0;
    foreach (q[k]) begin
      if (q[k].age == FU_LAT && !st && !fl) begin
        ew = 1'b1; wd = q[k].dst; wr = q[k].rob;
      end
    end
    chk("wb_valid", 32'(wb_valid), 32'(ew));
    chk("wb_phys", 32'(wb_phys), 32'(wd));
    chk("wb_rob", 32'(wb_rob_idx), 32'(wr));
    chk("inflight", 32'(inflight_cnt), 32'(q.size()));
    chk("busy", 32'(busy), (q.size() != 0) ? 32'd1 : 32'd0);
    cur_idx = e_idx;
  endtask

  task automatic tick;
    op_t nq[$];
    op_t o;
    logic [1:0] ci;
    @(posedge clk);
    if (!rst_n || flush) begin
      q.delete();
      if (!rst_n) m_ptr = 0;
    end else if (!fu_stall) begin
      foreach (q[k]) begin
        if (q[k].age < FU_LAT) begin
          o = q[k];
          o.age = o.age + 1;
          nq.push_back(o);
        end
      end
      if (cur_idx >= 0) begin
        ci = 2'(cur_idx);
        o.dst = int'(req_dst[ci]);
        o.rob = int'(req_rob_idx[ci]);
        o.age = 1;
        nq.push_back(o);
        m_ptr = (cur_idx + 1) % NUM_RS;
      end
      q = nq;
    end
    @(negedge clk);
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    req_valid = '0; fu_stall = 1'b0; flush = 1'b0;
    @(posedge clk);
    @(negedge clk);
    q.delete();
    m_ptr = 0;
    cur_idx = -1;
    rst_n = 1'b1;
  endtask

  vec_t tbl[14];
  int   wb_cyc[$];
  int   wb_dst[$];

  initial begin
    tbl[0]  = '{4'b1111, 1'b0, 1'b0, 4'b0001};
    tbl[1]  = '{4'b1111, 1'b0, 1'b0, 4'b0010};
    tbl[2]  = '{4'b1111, 1'b0, 1'b0, 4'b0100};
    tbl[3]  = '{4'b1111, 1'b0, 1'b0, 4'b1000};
    tbl[4]  = '{4'b1111, 1'b0, 1'b0, 4'b0001};
    tbl[5]  = '{4'b1111, 1'b1, 1'b0, 4'b0000};
    tbl[6]  = '{4'b0110, 1'b0, 1'b0, 4'b0010};
    tbl[7]  = '{4'b0110, 1'b0, 1'b0, 4'b0100};
    tbl[8]  = '{4'b0110, 1'b0, 1'b1, 4'b0000};
    tbl[9]  = '{4'b0011, 1'b0, 1'b0, 4'b0001};
    tbl[10] = '{4'b1000, 1'b0, 1'b0, 4'b1000};
    tbl[11] = '{4'b0000, 1'b0, 1'b0, 4'b0000};
    tbl[12] = '{4'b1111, 1'b1, 1'b1, 4'b0000};
    tbl[13] = '{4'b0101, 1'b0, 1'b0, 4'b0001};

    rst_n = 1'b0;
    req_valid = '0; fu_stall = 1'b0; flush = 1'b0;
    set_fields();
    @(negedge clk);

    // Reset state: registered outputs zero, grant still follows requests.
    drive(4'b0110, 1'b0, 1'b0);
    chk("rst_grant", 32'(grant), 32'b0010);
    chk("rst_inflight", 32'(inflight_cnt), 32'd0);
    tick();
    do_reset();

    // Round-robin grant table.
    foreach (tbl[i]) begin
      drive(tbl[i].rv, tbl[i].st, tbl[i].fl);
      chk($sformatf("tbl%0d_grant", i), 32'(grant), 32'(tbl[i].g));
      tick();
    end

    // Single op latency: grant cycle 10 broadcasts in cycle 13 only.
    do_reset();
    req_dst[2] = 6'd17;
    req_rob_idx[2] = 4'd5;
    for (int c = 0; c < 16; c++) begin
      drive((c == 10) ? 4'b0100 : 4'b0000, 1'b0, 1'b0);
      chk($sformatf("lat_wb_c%0d", c), 32'(wb_valid), (c == 13) ? 32'd1 : 32'd0);
      if (c == 13) begin
        chk("lat_phys", 32'(wb_phys), 32'd17);
        chk("lat_rob", 32'(wb_rob_idx), 32'd5);
      end
      tick();
    end
    set_fields();

    // Stall holds pipeline and pointer; broadcasts resume in order afterwards.
    do_reset();
    drive(4'b1111, 1'b0, 1'b0); tick();
    drive(4'b1111, 1'b0, 1'b0); tick();
    for (int c = 2; c < 4; c++) begin
      drive(4'b1111, 1'b1, 1'b0);
      chk("stall_grant", 32'(grant), 32'd0);
      chk("stall_inflight", 32'(inflight_cnt), 32'd2);
      tick();
    end
    for (int c = 4; c < 10; c++) begin
      drive(4'b0000, 1'b0, 1'b0);
      if (wb_valid) begin
        wb_cyc.push_back(c);
        wb_dst.push_back(int'(wb_phys));
      end
      tick();
    end
    chk("stall_wb_count", 32'(wb_dst.size()), 32'd2);
    if (wb_dst.size() == 2) begin
      chk("stall_wb_first", 32'(wb_dst[0]), 32'd10);
      chk("stall_wb_second", 32'(wb_dst[1]), 32'd11);
      chk("stall_wb_b2b", 32'(wb_cyc[1] - wb_cyc[0]), 32'd1);
    end

    // Flush with three ops in flight.
    do_reset();
    for (int c = 0; c < 3; c++) begin drive(4'b1111, 1'b0, 1'b0); tick(); end
    drive(4'b1111, 1'b0, 1'b1);
    chk("flush_grant", 32'(grant), 32'd0);
    chk("flush_wb", 32'(wb_valid), 32'd0);
    tick();
    drive(4'b0000, 1'b0, 1'b0);
    chk("flush_inflight", 32'(inflight_cnt), 32'd0);
    tick();
    for (int c = 0; c < 5; c++) begin
      drive(4'b0000, 1'b0, 1'b0);
      chk("flush_no_wb", 32'(wb_valid), 32'd0);
      tick();
    end

    // Flush and stall together with the last stage occupied.
    do_reset();
    drive(4'b0100, 1'b0, 1'b0); tick();
    drive(4'b0000, 1'b0, 1'b0); tick();
    drive(4'b0000, 1'b0, 1'b0); tick();
    drive(4'b0000, 1'b1, 1'b1);
    chk("fs_wb", 32'(wb_valid), 32'd0);
    tick();
    for (int c = 0; c < 3; c++) begin
      drive(4'b0000, 1'b0, 1'b0);
      chk("fs_inflight", 32'(inflight_cnt), 32'd0);
      chk("fs_no_wb", 32'(wb_valid), 32'd0);
      tick();
    end

    // Asynchronous reset in the middle of a full pipeline.
    do_reset();
    drive(4'b0001, 1'b0, 1'b0); tick();
    drive(4'b0010, 1'b0, 1'b0); tick();
    drive(4'b0100, 1'b0, 1'b0); tick();
    drive(4'b0000, 1'b0, 1'b0);
    chk("arst_pre_inflight", 32'(inflight_cnt), 32'd3);
    rst_n = 1'b0;
    #1;
    chk("arst_wb", 32'(wb_valid), 32'd0);
    chk("arst_phys", 32'(wb_phys), 32'd0);
    chk("arst_inflight", 32'(inflight_cnt), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    tick();
    rst_n = 1'b1;
    drive(4'b1111, 1'b0, 1'b0);
    chk("arst_ptr_grant", 32'(grant), 32'b0001);
    tick();
    for (int c = 0; c < 4; c++) begin drive(4'b0000, 1'b0, 1'b0); tick(); end

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NUM_RS; i++) begin
        req_dst[i]     = PR_BITS'($urandom);
        req_rob_idx[i] = ROB_BITS'($urandom);
      end
      drive(4'($urandom), ($urandom_range(4) == 0), ($urandom_range(19) == 0));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
